// File: rtl/pu_sequencer.sv
// rtl/pu_sequencer.sv - serial vector feeder and load_mult/load_sum sequencer for the 4-lane FP32 ProcessUnit
// Optional 16-bit job counter when PU_SEQ_JOBCNT_EN is defined.
module pu_sequencer #(
  parameter int WIDTH  = 32,
  parameter int N_IN   = 4,
  parameter int SETTLE = 0
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [WIDTH-1:0]            in_data_i,
  input  logic                        w_we_i,
  input  logic [1:0]                  w_addr_i,
  input  logic [WIDTH-1:0]            w_data_i,
  output logic [N_IN-1:0][WIDTH-1:0]  pu_x_o,
  output logic [N_IN-1:0][WIDTH-1:0]  pu_w_o,
  output logic                        pu_load_mult_o,
  output logic                        pu_load_sum_o,
  input  logic [WIDTH-1:0]            pu_out_i,
  input  logic                        pu_s_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [WIDTH-1:0]            res_data_o,
  output logic                        res_s_o
`ifdef PU_SEQ_JOBCNT_EN
  ,
  output logic [15:0]                 job_count_o,
  input  logic                        job_count_clr_i
`endif
);

  localparam int IDX_W = $clog2(N_IN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [3:0] WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  localparam logic [2:0] ST_FILL = 3'd0;
  localparam logic [2:0] ST_MULT = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SUM  = 3'd3;
  localparam logic [2:0] ST_CAPT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic [2:0]                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [3:0]                  wait_q, wait_d;
  logic [N_IN-1:0][WIDTH-1:0]  x_q, x_d;
  logic [N_IN-1:0][WIDTH-1:0]  w_q, w_d;
  logic [WIDTH-1:0]            res_data_q, res_data_d;
  logic                        res_s_q, res_s_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    x_d        = x_q;
    w_d        = w_q;
    res_data_d = res_data_q;
    res_s_d    = res_s_q;

    // Weight writes land in any state; the PU sees them from the following cycle.
    if (w_we_i) begin
      w_d[w_addr_i] = w_data_i;
    end

    case (state_q)
      ST_FILL: begin
        if (in_valid_i) begin
          x_d[idx_q] = in_data_i;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_MULT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_MULT: begin
        wait_d  = 4'd0;
        state_d = (SETTLE > 0) ? ST_WAIT : ST_SUM;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_SUM;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_SUM:  state_d = ST_CAPT;
      ST_CAPT: begin
        res_data_d = pu_out_i;
        res_s_d    = pu_s_i;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_FILL;
      idx_q      <= '0;
      wait_q     <= 4'd0;
      x_q        <= '0;
      w_q        <= '0;
      res_data_q <= '0;
      res_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      x_q        <= x_d;
      w_q        <= w_d;
      res_data_q <= res_data_d;
      res_s_q    <= res_s_d;
    end
  end

  assign in_ready_o     = (state_q == ST_FILL);
  assign pu_load_mult_o = (state_q == ST_MULT);
  assign pu_load_sum_o  = (state_q == ST_SUM);
  assign res_valid_o    = (state_q == ST_DONE);
  assign pu_x_o         = x_q;
  assign pu_w_o         = w_q;
  assign res_data_o     = res_data_q;
  assign res_s_o        = res_s_q;

`ifdef PU_SEQ_JOBCNT_EN
  logic [15:0] job_cnt_q, job_cnt_d;

  // Clear dominates a same-cycle completion.
  always_comb begin
    job_cnt_d = job_cnt_q;
    if (job_count_clr_i) begin
      job_cnt_d = 16'd0;
    end else if ((state_q == ST_DONE) && res_ready_i) begin
      job_cnt_d = job_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      job_cnt_q <= 16'd0;
    end else begin
      job_cnt_q <= job_cnt_d;
    end
  end

  assign job_count_o = job_cnt_q;
`endif

endmodule

// File: tb/tb_pu_sequencer.sv
// tb/tb_pu_sequencer.sv - bench for pu_sequencer: SETTLE=0 and SETTLE=3 instances against a timestamp model
// Honours PU_SEQ_JOBCNT_EN.
module tb_pu_sequencer;

  localparam logic [31:0] F_ONE = 32'h3F800000;
  localparam logic [31:0] F_TWO = 32'h40000000;
  localparam logic [31:0] F_M1  = 32'hBF800000;
  localparam logic [31:0] F_3   = 32'h40400000;
  localparam logic [31:0] F_8   = 32'h41000000;
  localparam logic [31:0] F_9   = 32'h41100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        w_we;
  logic [1:0]  w_addr;
  logic [31:0] w_data;
  logic        res_ready;

  logic             in_ready [2];
  logic [3:0][31:0] pu_x [2];
  logic [3:0][31:0] pu_w [2];
  logic             lm [2];
  logic             ls [2];
  logic [31:0]      pu_out [2];
  logic             pu_s [2];
  logic             rv [2];
  logic [31:0]      rd [2];
  logic             rs [2];
`ifdef PU_SEQ_JOBCNT_EN
  logic             jc_clr;
  logic [15:0]      jc [2];
  int               mjc [2];
`endif

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:23] == 8'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real dot(input logic [3:0][31:0] x, input logic [3:0][31:0] w);
    real s;
    s = 0.0;
    for (int i = 0; i < 4; i++) s = s + f2r(x[i]) * f2r(w[i]);
    return s;
  endfunction

  // Behavioural PU: products registered on load_mult, sum on load_sum, ReLU on the output.
  real mq [2];
  real sq [2];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (lm[g]) mq[g] <= dot(pu_x[g], pu_w[g]);
      if (ls[g]) sq[g] <= mq[g];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign pu_out[g] = (sq[g] > 0.0) ? r2f(sq[g]) : 32'h0;
    assign pu_s[g]   = (sq[g] > 0.0);

    pu_sequencer #(.WIDTH(32), .N_IN(4), .SETTLE(g * 3)) u_dut (
      .clock_i        (clk),
      .reset_i        (reset),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready[g]),
      .in_data_i      (in_data),
      .w_we_i         (w_we),
      .w_addr_i       (w_addr),
      .w_data_i       (w_data),
      .pu_x_o         (pu_x[g]),
      .pu_w_o         (pu_w[g]),
      .pu_load_mult_o (lm[g]),
      .pu_load_sum_o  (ls[g]),
      .pu_out_i       (pu_out[g]),
      .pu_s_i         (pu_s[g]),
      .res_valid_o    (rv[g]),
      .res_ready_i    (res_ready),
      .res_data_o     (rd[g]),
      .res_s_o        (rs[g])
`ifdef PU_SEQ_JOBCNT_EN
      ,
      .job_count_o    (jc[g]),
      .job_count_clr_i(jc_clr)
`endif
    );
  end

  // Reference model: per instance, a busy flag plus the edge index E0 of the last accepted word.
  int               cyc = 0;
  bit               rst_last;
  int               busy [2];
  int               cnt [2];
  int               e0 [2];
  logic [3:0][31:0] mx [2];
  logic [3:0][31:0] mw [2];
  logic [31:0]      ed [2];
  logic             es [2];

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_last = reset;
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        busy[g] = 0; cnt[g] = 0; e0[g] = -100; mx[g] = '0; mw[g] = '0;
`ifdef PU_SEQ_JOBCNT_EN
        mjc[g] = 0;
`endif
      end else begin
        bit  hs;
        real d;
        hs = (busy[g] != 0) && (cyc - 1 >= e0[g] + 3 + 3 * g) && res_ready;
        if (w_we) mw[g][w_addr] = w_data;
        if (busy[g] == 0) begin
          if (in_valid) begin
            mx[g][cnt[g]] = in_data;
            cnt[g] = cnt[g] + 1;
            if (cnt[g] == 4) begin
              cnt[g] = 0; busy[g] = 1; e0[g] = cyc;
              d = dot(mx[g], mw[g]);
              ed[g] = (d > 0.0) ? r2f(d) : 32'h0;
              es[g] = (d > 0.0);
            end
          end
        end else if (hs) begin
          busy[g] = 0;
`ifdef PU_SEQ_JOBCNT_EN
          mjc[g] = (mjc[g] + 1) % 65536;
`endif
        end
`ifdef PU_SEQ_JOBCNT_EN
        if (jc_clr) mjc[g] = 0;
`endif
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  bit          pin_on = 1'b0;
  logic [31:0] pin_d  = 32'h0;
  logic        pin_s  = 1'b0;

  task automatic cmp(input string name, input int g, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, g, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int g = 0; g < 2; g++) begin
        bit vexp;
        vexp = (busy[g] != 0) && (cyc >= e0[g] + 3 + 3 * g);
        cmp("in_ready", g, 128'(in_ready[g]), 128'(busy[g] == 0));
        cmp("res_valid", g, 128'(rv[g]), 128'(vexp));
        cmp("load_mult", g, 128'(lm[g]), 128'((busy[g] != 0) && (cyc == e0[g])));
        cmp("load_sum", g, 128'(ls[g]), 128'((busy[g] != 0) && (cyc == e0[g] + 1 + 3 * g)));
        cmp("pu_x", g, 128'(pu_x[g]), 128'(mx[g]));
        cmp("pu_w", g, 128'(pu_w[g]), 128'(mw[g]));
        if (vexp) begin
          cmp("res_data", g, 128'(rd[g]), 128'(ed[g]));
          cmp("res_s", g, 128'(rs[g]), 128'(es[g]));
          if (pin_on) begin
            cmp("pin_res_data", g, 128'(rd[g]), 128'(pin_d));
            cmp("pin_res_s", g, 128'(rs[g]), 128'(pin_s));
          end
        end
        if (rst_last) begin
          cmp("rst_res_data", g, 128'(rd[g]), 128'h0);
          cmp("rst_res_s", g, 128'(rs[g]), 128'h0);
        end
`ifdef PU_SEQ_JOBCNT_EN
        cmp("job_count", g, 128'(jc[g]), 128'(mjc[g]));
`endif
      end
    end
  end

  task automatic send_word(input logic [31:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [31:0] d, input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap && i > 0) begin
        @(posedge clk); #1;
      end
      send_word(d);
    end
  endtask

  task automatic write_w(input logic [1:0] a, input logic [31:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (in_ready[0] && in_ready[1]) return;
      @(posedge clk); #1;
    end
    $display("FAIL wait_idle: in_ready never returned within 60 cycles");
    $fatal(1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    res_ready = 1'b1;
`ifdef PU_SEQ_JOBCNT_EN
    jc_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic: 4 x (1.0 * 2.0) = 8.0
    for (int a = 0; a < 4; a++) write_w(2'(a), F_TWO);
    pin_d = F_8; pin_s = 1'b1; pin_on = 1'b1;
    send_vec(F_ONE, 1'b0);
    wait_idle();

    // ReLU: negative sum clamps to zero
    for (int a = 0; a < 4; a++) write_w(2'(a), F_M1);
    pin_d = 32'h0; pin_s = 1'b0;
    send_vec(F_ONE, 1'b0);
    wait_idle();

    // Backpressure in DONE
    for (int a = 0; a < 4; a++) write_w(2'(a), F_TWO);
    pin_d = F_8; pin_s = 1'b1;
    res_ready = 1'b0;
    send_vec(F_ONE, 1'b0);
    for (int i = 0; i < 30 && !(rv[0] && rv[1]); i++) begin
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_idle();

    // Gapped input
    send_vec(F_ONE, 1'b1);
    wait_idle();

    // Weight write in the MULT cycle: this job uses 2.0, the next one 3.0
    send_vec(F_ONE, 1'b0);
    write_w(2'd0, F_3);
    wait_idle();
    pin_d = F_9;
    send_vec(F_ONE, 1'b0);
    wait_idle();

    // Reset during SUM of the SETTLE=0 instance
    pin_on = 1'b0;
    send_vec(F_ONE, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) write_w(2'(a), F_TWO);
    pin_d = F_8; pin_s = 1'b1; pin_on = 1'b1;
    send_vec(F_ONE, 1'b0);
    wait_idle();
    pin_on = 1'b0;

    // Randomized traffic with small exact integer operands
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = r2f(real'(int'($urandom_range(0, 8)) - 4));
      res_ready = ($urandom_range(0, 3) != 0);
      w_we      = ($urandom_range(0, 3) == 0);
      w_addr    = 2'($urandom_range(0, 3));
      w_data    = r2f(real'(int'($urandom_range(0, 8)) - 4));
`ifdef PU_SEQ_JOBCNT_EN
      jc_clr    = ($urandom_range(0, 19) == 0);
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0; w_we = 1'b0; res_ready = 1'b1;
`ifdef PU_SEQ_JOBCNT_EN
    jc_clr = 1'b0;
`endif
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
